// File: rtl/serial_tx_fifo_if.sv
// Write-side bus of serial_tx_fifo.
//   data      character to enqueue
//   new_data  write strobe
//   full      FIFO holds FIFO_DEPTH entries
//   overflow  one-cycle pulse after a dropped write
//   level     current FIFO occupancy
// master: the command logic that writes characters; slave: the transmitter.
interface serial_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) ();
  logic [DATA_BITS-1:0]         data;
  logic                         new_data;
  logic                         full;
  logic                         overflow;
  logic [$clog2(FIFO_DEPTH):0]  level;

  modport master (
    output data, new_data,
    input  full, overflow, level
  );

  modport slave (
    input  data, new_data,
    output full, overflow, level
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// UART-style serial transmitter with an integrated transmit FIFO.
// Optional parity is enabled by defining SERIAL_TX_PARITY_EN, which adds the
// parity_odd port and a PARITY bit between the last data bit and the stop bits.
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset
//   parity_odd  1 = odd parity, 0 = even (SERIAL_TX_PARITY_EN only)
//   block_tx    inhibits starting a new frame, never aborts one
//   tx          serial line, idles high, registered
//   busy        frame in progress, FIFO non-empty, or blocked
//   wr          write bus (data, new_data, full, overflow, level)
module serial_tx_fifo #(
  parameter int unsigned CLK_PER_BIT = 25,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SERIAL_TX_PARITY_EN
  input  logic            parity_odd,
`endif
  input  logic            block_tx,
  output logic            tx,
  output logic            busy,
  serial_tx_fifo_if.slave wr
);

  localparam int unsigned CntW = $clog2(CLK_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef SERIAL_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 block_q;
  logic                 overflow_q;
  logic [LvlW-1:0]      level_q, level_d;
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic full, empty, push, pop, bit_end, start_ok;
  logic [DATA_BITS-1:0] head;

  assign full     = (level_q == LvlW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  // full is taken from the pre-edge level, so a same-cycle pop cannot rescue a write
  assign push     = wr.new_data & ~full;
  assign bit_end  = (cnt_q == CntW'(CLK_PER_BIT - 1));
  assign start_ok = ~empty & ~block_q;
  assign head     = mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (start_ok) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        // idx counts stop bits here
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (start_ok) begin
              pop     = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shift_d = head;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
      StParity: tx_d = parity_q ^ parity_odd;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      block_q    <= 1'b0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      block_q    <= block_tx;
      overflow_q <= wr.new_data & full;
      level_q    <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr.data;
  end

  assign tx          = tx_q;
  assign busy        = (state_q != StIdle) | ~empty | block_q;
  assign wr.full     = full;
  assign wr.overflow = overflow_q;
  assign wr.level    = level_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo with CLK_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4.
// Stimulus pushes expected characters into exp_q; a UART receiver process decodes
// tx and compares each received frame against the head of exp_q.
module tb_serial_tx_fifo;
`ifdef SERIAL_TX_PARITY_EN
  localparam int Frame = 44;
`else
  localparam int Frame = 40;
`endif

  logic clk = 1'b0;
  logic rst;
  logic block_tx;
  logic tx;
  logic busy;
`ifdef SERIAL_TX_PARITY_EN
  logic parity_odd;
`endif

  serial_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) wr_if ();

  serial_tx_fifo #(
    .CLK_PER_BIT(4),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SERIAL_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .block_tx  (block_tx),
    .tx        (tx),
    .busy      (busy),
    .wr        (wr_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  int rx_cnt = 0;
  logic saw_rst = 1'b0;
  logic prev_tx = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) if (rst === 1'b0) saw_rst = 1'b1;

  // Receiver: samples mid-bit (offset 2 of each 4-cycle bit)
  initial begin
    logic [7:0] ch;
    logic       st_ok;
    logic       par;
    int         t0;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && prev_tx === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        saw_rst = 1'b0;
        repeat (2) @(negedge clk);
        st_ok = (tx === 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          ch[b] = tx;
        end
`ifdef SERIAL_TX_PARITY_EN
        repeat (4) @(negedge clk);
        par = tx;
`endif
        repeat (4) @(negedge clk);
        if (!saw_rst) begin
          logic [7:0] e;
          starts.push_back(t0);
          rx_cnt++;
          chk("start_bit", int'(st_ok), 1);
          chk("stop_bit", int'(tx), 1);
          chk("frame_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("frame_data", int'(ch), int'(e));
`ifdef SERIAL_TX_PARITY_EN
            chk("parity_bit", int'(par), int'((^e) ^ parity_odd));
`endif
          end
        end
        prev_tx = 1'b1;
      end else begin
        prev_tx = tx;
      end
    end
  end

  // Called just after a rising edge; returns just after the write edge.
  task automatic write1(input logic [7:0] d);
    wr_if.data     = d;
    wr_if.new_data = 1'b1;
    exp_q.push_back(d);
    @(posedge clk);
    #1 wr_if.new_data = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_cnt < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", rx_cnt, n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, wcyc, c, k;
    rst = 1'b0;
    block_tx = 1'b0;
    wr_if.data = '0;
    wr_if.new_data = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_odd = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(wr_if.full), 0);
    chk("rst_overflow", int'(wr_if.overflow), 0);
    chk("rst_level", int'(wr_if.level), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(3);

    // Single 0x55: START 2 edges after the write, busy high for 41 edges
    n0 = rx_cnt;
    write1(8'h55);
    @(negedge clk);
    wcyc = cyc;
    chk("single_level", int'(wr_if.level), 1);
    chk("single_busy", int'(busy), 1);
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("single_busy_len", k, 41);
    wait_rx(n0 + 1, 20);
    chk("single_start_lat", starts[n0] - wcyc, 2);
    idle(10);

    // Burst 0x01..0x06 on consecutive cycles; 0x06 is dropped
    n0 = rx_cnt;
    for (int i = 1; i <= 6; i++) begin
      wr_if.data = 8'(i);
      wr_if.new_data = 1'b1;
      if (i <= 5) exp_q.push_back(8'(i));
      @(negedge clk);
      if (i == 6) chk("burst_full", int'(wr_if.full), 1);
      @(posedge clk);
      #1;
    end
    wr_if.new_data = 1'b0;
    @(negedge clk);
    chk("burst_overflow", int'(wr_if.overflow), 1);
    chk("burst_level", int'(wr_if.level), 4);
    @(negedge clk);
    chk("burst_overflow_pulse", int'(wr_if.overflow), 0);
    wait_rx(n0 + 5, 300);
    for (int j = 0; j < 4; j++) chk("burst_gap", starts[n0 + j + 1] - starts[n0 + j], Frame);
    idle(10);
    chk("burst_drained", int'(wr_if.level), 0);

    // Blocked start
    block_tx = 1'b1;
    idle(1);
    n0 = rx_cnt;
    write1(8'hA3);
    repeat (10) @(negedge clk);
    chk("block_tx_high", int'(tx), 1);
    chk("block_busy", int'(busy), 1);
    chk("block_level", int'(wr_if.level), 1);
    chk("block_no_frame", rx_cnt, n0);
    @(posedge clk);
    #1 block_tx = 1'b0;
    c = cyc;
    wait_rx(n0 + 1, 60);
    // release seen at the next edge, pop one edge later, tx low one edge after that
    chk("release_latency", starts[n0] - c, 3);
    idle(10);

    // Block raised mid-DATA: current frame completes, 0x11 waits
    n0 = rx_cnt;
    write1(8'h20);
    write1(8'h11);
    idle(10);
    block_tx = 1'b1;
    wait_rx(n0 + 1, 80);
    repeat (20) @(negedge clk);
    chk("midblock_tx_high", int'(tx), 1);
    chk("midblock_level", int'(wr_if.level), 1);
    chk("midblock_busy", int'(busy), 1);
    chk("midblock_no_frame", rx_cnt, n0 + 1);
    @(posedge clk);
    #1 block_tx = 1'b0;
    wait_rx(n0 + 2, 80);
    idle(10);

`ifdef SERIAL_TX_PARITY_EN
    // Parity: 0x07 has odd weight -> even parity bit 1, odd parity bit 0
    n0 = rx_cnt;
    parity_odd = 1'b0;
    write1(8'h07);
    write1(8'h07);
    wait_rx(n0 + 2, 150);
    chk("parity_frame_len", starts[n0 + 1] - starts[n0], 44);
    idle(10);
    parity_odd = 1'b1;
    write1(8'h07);
    wait_rx(n0 + 3, 80);
    idle(10);
`endif

    // Reset mid-DATA with two entries queued
    write1(8'h3C);
    write1(8'h5A);
    write1(8'h96);
    idle(10);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_level", int'(wr_if.level), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_full", int'(wr_if.full), 0);
    rst = 1'b1;
    exp_q.delete();
    n0 = rx_cnt;
    repeat (100) @(negedge clk);
    chk("midrst_no_frame", rx_cnt, n0);
    chk("midrst_tx_idle", int'(tx), 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
